fetch_queue: RTL and testbench

- Sits between the instruction fetch unit (PC register, +4 adder, redirect mux) and the decode stage.
- Issues instruction-memory requests for the fetch PC using a valid/ready handshake, and tracks the PC / PC+4 of each request.
- Buffers in-order memory responses in a DEPTH-entry circular queue and presents them to decode with valid/stall.
- On a taken branch/jump, flushes all wrong-path entries and discards in-flight responses.

---
 rtl/fetch_queue_if.sv | 20 ++
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between fetch_queue (master) and the I-side memory (slave).
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: issues I-memory requests for PCF, buffers in-order responses in a circular
// queue, presents them to decode, and discards wrong-path fetches on a redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCplus4F,
    output logic            stallF,
    fetch_queue_if.master   imem,
    input  logic            flushD,
    input  logic            stallD,
    output logic            validD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCplus4D
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // drop can exceed DEPTH when redirects arrive back to back against a slow memory
    localparam int DW = CW + 1;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  pc4_q   [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    tail_q, tail_d, fill_q, fill_d, head_q, head_d;
    logic [CW-1:0]    used_q, used_d, out_q, out_d;
    logic [DW-1:0]    drop_q, drop_d;

    logic fire, deq, rsp_drop, rsp_inflight, rsp_take;

    assign imem.imem_req_valid = reset & ~flushD & (used_q < FULL);
    assign imem.imem_req_addr  = PCF;
    assign fire                = imem.imem_req_valid & imem.imem_req_ready;
    assign stallF              = ~reset | (~fire & ~flushD);

    assign validD = filled_q[head_q] & (used_q != '0);
    assign deq    = validD & ~stallD & ~flushD;

    // A response is either owed to a flushed request, or fills the oldest unfilled entry.
    assign rsp_drop     = imem.imem_rsp_valid & (drop_q != '0);
    assign rsp_inflight = imem.imem_rsp_valid & (drop_q == '0) & (out_q != '0);
    assign rsp_take     = rsp_inflight & ~flushD;

    // NOTE: every variable gets a default at the top of a combinational block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tail_d   = tail_q;
        fill_d   = fill_q;
        head_d   = head_q;
        used_d   = used_q;
        out_d    = out_q;
        filled_d = filled_q;
        drop_d   = drop_q - DW'(rsp_drop);
        if (flushD) begin
            tail_d   = tail_q;
            fill_d   = tail_q;
            head_d   = tail_q;
            used_d   = '0;
            out_d    = '0;
            filled_d = '0;
            drop_d   = drop_d + DW'(out_q) - DW'(rsp_inflight);
        end else begin
            if (fire) begin
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + PW'(1);
            end
            if (rsp_take) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PW'(1);
            end
            if (deq) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PW'(1);
            end
            used_d = used_q + CW'(fire) - CW'(deq);
            out_d  = out_q + CW'(fire) - CW'(rsp_take);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_q   <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            used_q   <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            filled_q <= '0;
        end else begin
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            head_q   <= head_d;
            used_q   <= used_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            filled_q <= filled_d;
        end
    end

    // NOTE: the payload array is not reset; the filled bits alone decide whether an
    // entry is visible, so stale payload is never observed.
    always_ff @(posedge clk) begin
        if (fire) begin
            pc_q[tail_q]  <= PCF;
            pc4_q[tail_q] <= PCplus4F;
        end
        if (rsp_take) begin
            instr_q[fill_q] <= imem.imem_rsp_data;
        end
    end

    always_comb begin
        InstrD   = NOP;
        PCD      = '0;
        PCplus4D = '0;
        if (validD) begin
            InstrD   = instr_q[head_q];
            PCD      = pc_q[head_q];
            PCplus4D = pc4_q[head_q];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed cycle table, then model-driven sequences
// (in-order memory with variable latency plus a PC scoreboard) for stall, flush and reset cases.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PCplus4F, InstrD, PCD, PCplus4D;
    logic        stallF, flushD, stallD, validD;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .PCF      (PCF),
        .PCplus4F (PCplus4F),
        .stallF   (stallF),
        .imem     (bus),
        .flushD   (flushD),
        .stallD   (stallD),
        .validD   (validD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCplus4D (PCplus4D)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model (pending responses in order) and decode-side scoreboard.
    int          due_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pc_m;
    int          cyc   = 0;
    int          fires = 0;
    logic        s_validd, s_reqv, s_stallf, s_rsp;
    logic [31:0] s_addr;

    task automatic cycle(input bit rdy, input bit sd, input bit fl, input logic [31:0] tgt, input int lat);
        bit fire;
        PCF                = pc_m;
        PCplus4F           = pc_m + 32'd4;
        flushD             = fl;
        stallD             = sd;
        bus.imem_req_ready = rdy;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        check("req_addr", bus.imem_req_addr, PCF);
        checkb("stallF_rel", stallF, !(bus.imem_req_valid && rdy) && !fl);
        if (fl) checkb("reqv_in_flush", bus.imem_req_valid, 1'b0);
        if (validD) begin
            check("instr", InstrD, instr_of(PCD));
            check("pc4", PCplus4D, PCD + 32'd4);
            if (!sd && !fl) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deq_unexpected: got PCD %h expected no dequeue (t=%0t)", PCD, $time);
                end else begin
                    check("deq_pc", PCD, exp_q.pop_front());
                end
            end
        end else begin
            check("idle_instr", InstrD, NOP);
            check("idle_pc", PCD, 32'h0);
        end
        s_validd = validD;
        s_reqv   = bus.imem_req_valid;
        s_stallf = stallF;
        s_rsp    = bus.imem_rsp_valid;
        s_addr   = bus.imem_req_addr;
        fire     = bus.imem_req_valid && rdy;
        if (fire) begin
            fires++;
            due_q.push_back(cyc + lat);
            addr_q.push_back(PCF);
            exp_q.push_back(PCF);
        end
        if (fl) exp_q.delete();
        if (!stallF) pc_m = fl ? tgt : pc_m + 32'd4;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || due_q.size() != 0) && n < 60) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'h0);
        checkb("drain_validD", validD, 1'b0);
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        flushD             = 1'b0;
        stallD             = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        due_q.delete();
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pcf;
        logic        rdy;
        logic        rv;
        logic [31:0] raddr;
        logic        sd;
        logic        e_stallf;
        logic        e_reqv;
        logic        e_validd;
        logic [31:0] e_pcd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pcf    rdy   rv    raddr  sd    stallF reqv validD pcd
        vecs[0]  = '{32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[1]  = '{32'h04, 1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[2]  = '{32'h08, 1'b1, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        vecs[3]  = '{32'h0C, 1'b1, 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04};
        vecs[4]  = '{32'h10, 1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
        vecs[5]  = '{32'h14, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
        vecs[6]  = '{32'h18, 1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b1, 32'h08};
        vecs[7]  = '{32'h18, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h08};
        vecs[8]  = '{32'h18, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08};
        vecs[9]  = '{32'h18, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0C};
        vecs[10] = '{32'h1C, 1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
        vecs[11] = '{32'h20, 1'b1, 1'b1, 32'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h14};
        vecs[12] = '{32'h24, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1, 32'h18};
        vecs[13] = '{32'h24, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1C};
        vecs[14] = '{32'h28, 1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20};
        vecs[15] = '{32'h28, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h24};
        vecs[16] = '{32'h28, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00};

        reset              = 1'b0;
        PCF                = 32'h0;
        PCplus4F           = 32'h4;
        flushD             = 1'b0;
        stallD             = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        @(posedge clk);
        #1;
        checkb("rst_validD", validD, 1'b0);
        checkb("rst_reqv", bus.imem_req_valid, 1'b0);
        checkb("rst_stallF", stallF, 1'b1);
        check("rst_instr", InstrD, NOP);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: streaming, fill to full under stallD, drain, ready gaps.
        for (int i = 0; i < 17; i++) begin
            PCF                = vecs[i].pcf;
            PCplus4F           = vecs[i].pcf + 32'd4;
            bus.imem_req_ready = vecs[i].rdy;
            bus.imem_rsp_valid = vecs[i].rv;
            bus.imem_rsp_data  = vecs[i].rv ? instr_of(vecs[i].raddr) : 32'h0;
            stallD             = vecs[i].sd;
            flushD             = 1'b0;
            #1;
            checkb($sformatf("v%0d_stallF", i), stallF, vecs[i].e_stallf);
            checkb($sformatf("v%0d_reqv", i), bus.imem_req_valid, vecs[i].e_reqv);
            check($sformatf("v%0d_addr", i), bus.imem_req_addr, vecs[i].pcf);
            checkb($sformatf("v%0d_validD", i), validD, vecs[i].e_validd);
            check($sformatf("v%0d_PCD", i), PCD, vecs[i].e_pcd);
            check($sformatf("v%0d_PC4D", i), PCplus4D, vecs[i].e_validd ? vecs[i].e_pcd + 32'd4 : 32'h0);
            check($sformatf("v%0d_InstrD", i), InstrD, vecs[i].e_validd ? instr_of(vecs[i].e_pcd) : NOP);
            @(posedge clk);
            #1;
        end

        // Fill from empty under stallD: exactly DEPTH accepts, then full.
        do_reset();
        pc_m = 32'h100;
        begin
            int f0 = fires;
            repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
            check("full_accepts", 32'(fires - f0), 32'd4);
            checkb("full_reqv", s_reqv, 1'b0);
            checkb("full_stallF", s_stallf, 1'b1);
        end
        drain();

        // Variable latency, toggling ready and random decode stalls.
        pc_m = 32'h1000;
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0, 32'h0,
                  int'($urandom_range(1, 3)));
        drain();

        // Flush with one queued entry and two requests in flight.
        pc_m = 32'h200;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        cycle(1'b0, 1'b0, 1'b1, 32'h300, 1);
        checkb("f1_pre_validD", s_validd, 1'b1);
        checkb("f1_stallF", s_stallf, 1'b0);
        checkb("f1_post_validD", validD, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checkb("f1_next_reqv", s_reqv, 1'b1);
        check("f1_next_addr", s_addr, 32'h300);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        drain();

        // Flush coinciding with a response and an unstalled valid entry.
        pc_m = 32'h400;
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 2);
        cycle(1'b1, 1'b0, 1'b1, 32'h500, 2);
        checkb("f2_pre_validD", s_validd, 1'b1);
        checkb("f2_pre_rsp", s_rsp, 1'b1);
        checkb("f2_post_validD", validD, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2);
        checkb("f2_next_reqv", s_reqv, 1'b1);
        check("f2_next_addr", s_addr, 32'h500);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0, 2);
        drain();

        // Asynchronous reset with three entries queued.
        pc_m = 32'h600;
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        checkb("r_pre_validD", validD, 1'b1);
        reset = 1'b0;
        #1;
        checkb("r_async_validD", validD, 1'b0);
        checkb("r_async_reqv", bus.imem_req_valid, 1'b0);
        checkb("r_async_stallF", stallF, 1'b1);
        do_reset();
        pc_m = 32'h700;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checkb("r_first_reqv", s_reqv, 1'b1);
        check("r_first_addr", s_addr, 32'h700);
        checkb("r_first_validD", s_validd, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
